// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between the core (fixed priority) and a loader port,
// with a starvation counter that forces a loader grant. Define ARB_STATS_EN for stat counters.
module dmem_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_en,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_din,
    output logic          c_stall,
    output logic [DW-1:0] c_dout,
    output logic          c_valid,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_din,
    output logic          l_gnt,
    output logic [DW-1:0] l_dout,
    output logic          l_valid,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_di,
    input  logic [DW-1:0] ram_dout
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]   stat_conflicts,
    output logic [15:0]   stat_forced
`endif
);

    typedef enum logic [1:0] {OwnNone, OwnC, OwnL} owner_e;

    localparam logic [CNT_W-1:0] Limit = CNT_W'(STARVE_LIMIT);

    owner_e           owner_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             force_l;
    logic             win_c;
    logic             win_l;

    // Gating by rst keeps every strobe low for the whole time reset is held.
    always_comb begin
        force_l = l_req && (wait_cnt_q == Limit);
        win_l   = !rst && (force_l || (l_req && !c_en));
        win_c   = !rst && c_en && !force_l;
    end

    always_comb begin
        ram_en   = win_l || win_c;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_di   = '0;
        if (win_l) begin
            ram_we   = l_we;
            ram_addr = l_addr;
            ram_di   = l_din;
        end else if (win_c) begin
            ram_we   = c_we;
            ram_addr = c_addr;
            ram_di   = c_din;
        end
        l_gnt   = win_l;
        c_stall = c_en && win_l;
        c_valid = !rst && (owner_q == OwnC);
        l_valid = !rst && (owner_q == OwnL);
        c_dout  = ram_dout;
        l_dout  = ram_dout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q    <= OwnNone;
            wait_cnt_q <= '0;
        end else begin
            if (win_c && !c_we) begin
                owner_q <= OwnC;
            end else if (win_l && !l_we) begin
                owner_q <= OwnL;
            end else begin
                owner_q <= OwnNone;
            end
            if (!l_req || win_l) begin
                wait_cnt_q <= '0;
            end else if (wait_cnt_q != Limit) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_conflicts <= '0;
            stat_forced    <= '0;
        end else begin
            if (c_en && l_req && (stat_conflicts != 16'hFFFF)) begin
                stat_conflicts <= stat_conflicts + 16'd1;
            end
            if (force_l && (stat_forced != 16'hFFFF)) begin
                stat_forced <= stat_forced + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic checked against a
// rule-level reference model and a behavioural 1-cycle-latency RAM.
module tb_dmem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_en, c_we, c_stall, c_valid;
    logic [31:0] c_addr, c_din, c_dout;
    logic        l_req, l_we, l_gnt, l_valid;
    logic [31:0] l_addr, l_din, l_dout;
    logic        ram_en, ram_we;
    logic [31:0] ram_addr, ram_di, ram_dout;
`ifdef ARB_STATS_EN
    logic [15:0] stat_conflicts, stat_forced;
    int          conf_m = 0;
    int          forc_m = 0;
`endif

    dmem_arbiter #(
        .AW(32), .DW(32), .STARVE_LIMIT(LIMIT), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .c_en(c_en), .c_we(c_we), .c_addr(c_addr), .c_din(c_din),
        .c_stall(c_stall), .c_dout(c_dout), .c_valid(c_valid),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_din(l_din),
        .l_gnt(l_gnt), .l_dout(l_dout), .l_valid(l_valid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
        .ram_dout(ram_dout)
`ifdef ARB_STATS_EN
        , .stat_conflicts(stat_conflicts), .stat_forced(stat_forced)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural block RAM, read-before-write, registered output.
    logic [31:0] ram_mem [256];
    always_ff @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr[9:2]] <= ram_di;
            ram_dout <= ram_mem[ram_addr[9:2]];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [256];
    int          denied = 0;
    logic        exp_cv = 1'b0, exp_lv = 1'b0;
    logic [31:0] exp_cd, exp_ld;
    logic        last_lw = 1'b0, last_stall = 1'b0;
    int          tests = 0;
    int          failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {31'd0, obs}, {31'd0, exp});
    endtask

    task automatic step(input logic ce, input logic cwe, input logic [31:0] ca,
                        input logic [31:0] cd, input logic lr, input logic lwe,
                        input logic [31:0] la, input logic [31:0] ld);
        logic f, lw, cw;
        @(negedge clk);
        c_en = ce; c_we = cwe; c_addr = ca; c_din = cd;
        l_req = lr; l_we = lwe; l_addr = la; l_din = ld;
        #1;
        f  = lr && (denied == LIMIT);
        lw = f || (lr && !ce);
        cw = ce && !f;
        chk1("l_gnt", l_gnt, lw);
        chk1("c_stall", c_stall, ce && lw);
        chk1("ram_en", ram_en, lw || cw);
        chk1("ram_we", ram_we, lw ? lwe : (cw ? cwe : 1'b0));
        chk("ram_addr", ram_addr, lw ? la : (cw ? ca : 32'd0));
        chk("ram_di", ram_di, lw ? ld : (cw ? cd : 32'd0));
        chk1("c_valid", c_valid, exp_cv);
        chk1("l_valid", l_valid, exp_lv);
        if (exp_cv) chk("c_dout", c_dout, exp_cd);
        if (exp_lv) chk("l_dout", l_dout, exp_ld);
`ifdef ARB_STATS_EN
        if (ce && lr) conf_m++;
        if (f) forc_m++;
`endif
        @(posedge clk);
        exp_cv = cw && !cwe;
        exp_lv = lw && !lwe;
        exp_cd = ref_mem[ca[9:2]];
        exp_ld = ref_mem[la[9:2]];
        if (lw && lwe) ref_mem[la[9:2]] = ld;
        if (cw && cwe) ref_mem[ca[9:2]] = cd;
        if (!lr || lw) denied = 0;
        else if (denied < LIMIT) denied++;
        last_lw    = lw;
        last_stall = ce && lw;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    logic        ce_r = 1'b0, cwe_r = 1'b0, l_act = 1'b0, lwe_r = 1'b0, lr_on;
    logic [31:0] ca_r = 0, cd_r = 0, la_r = 0, ld_r = 0;

    initial begin
        rst = 1'b1;
        c_en = 0; c_we = 0; c_addr = 0; c_din = 0;
        l_req = 0; l_we = 0; l_addr = 0; l_din = 0;
        #3;
        chk1("rst_ram_en", ram_en, 1'b0);
        chk1("rst_c_valid", c_valid, 1'b0);
        chk1("rst_l_valid", l_valid, 1'b0);
        c_en = 1'b1; l_req = 1'b1;
        #1;
        chk1("rst_req_ram_en", ram_en, 1'b0);
        chk1("rst_req_l_gnt", l_gnt, 1'b0);
        chk1("rst_req_c_stall", c_stall, 1'b0);
        c_en = 1'b0; l_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Fill every word so later reads are deterministic
        for (int i = 0; i < 256; i++) step(1'b1, 1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0, 0, 0);

        // Core-only read of 0xDEADBEEF
        step(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 32'h40, 32'd0, 1'b0, 1'b0, 0, 0);
        idle();

        // Loader write with idle core, then core reads it back
        step(1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 32'h100, 32'h12345678);
        step(1'b1, 1'b0, 32'h100, 0, 1'b0, 1'b0, 0, 0);
        idle();

        // Starvation: loader gets forced through on the 5th cycle
        lr_on = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step(1'b1, 1'b0, 32'h20, 0, lr_on, 1'b0, 32'h8, 0);
            if (last_lw) lr_on = 1'b0;
        end
        idle();

        // Interleave: C read then L read on consecutive cycles
        step(1'b1, 1'b0, 32'h0, 0, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 32'h4, 0);
        idle();
        idle();

        // Loader drops its request before a grant; the count restarts
        step(1'b1, 1'b0, 32'h10, 0, 1'b1, 1'b0, 32'hC, 0);
        step(1'b1, 1'b0, 32'h10, 0, 1'b1, 1'b0, 32'hC, 0);
        step(1'b1, 1'b0, 32'h10, 0, 1'b0, 1'b0, 32'hC, 0);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 32'h10, 0, 1'b1, 1'b0, 32'hC, 0);
        step(1'b1, 1'b0, 32'h10, 0, 1'b0, 1'b0, 0, 0);

        // Asynchronous reset between a granted core read and its return
        step(1'b1, 1'b0, 32'h40, 0, 1'b1, 1'b0, 32'h8, 0);
        step(1'b1, 1'b0, 32'h40, 0, 1'b1, 1'b0, 32'h8, 0);
        #2 rst = 1'b1;
        #1;
        chk1("mid_rst_c_valid", c_valid, 1'b0);
        chk1("mid_rst_ram_en", ram_en, 1'b0);
        chk1("mid_rst_l_gnt", l_gnt, 1'b0);
        chk1("mid_rst_c_stall", c_stall, 1'b0);
        rst = 1'b0;
        denied = 0; exp_cv = 1'b0; exp_lv = 1'b0;
`ifdef ARB_STATS_EN
        conf_m = 0; forc_m = 0;
`endif
        lr_on = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, 32'h40, 0, lr_on, 1'b0, 32'h8, 0);
            if (last_lw) lr_on = 1'b0;
        end

        // Randomized traffic honouring the hold-until-served protocols
        for (int n = 0; n < 400; n++) begin
            if (!last_stall) begin
                ce_r  = 1'($urandom_range(0, 1));
                cwe_r = 1'($urandom_range(0, 1));
                ca_r  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                cd_r  = $urandom;
            end
            if (!l_act && $urandom_range(0, 2) == 0) begin
                l_act = 1'b1;
                lwe_r = 1'($urandom_range(0, 1));
                la_r  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                ld_r  = $urandom;
            end else if (l_act && $urandom_range(0, 15) == 0) begin
                l_act = 1'b0;
            end
            step(ce_r, cwe_r, ca_r, cd_r, l_act, lwe_r, la_r, ld_r);
            if (last_lw) l_act = 1'b0;
        end
        idle();

`ifdef ARB_STATS_EN
        chk("stat_conflicts", {16'd0, stat_conflicts}, 32'(conf_m));
        chk("stat_forced", {16'd0, stat_forced}, 32'(forc_m));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
